sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised FIFO buffer for byte and word streams inside one clock domain. It generalises the team's original 8-bit/256-entry queue in three ways:
- configurable data width, depth and almost-full/almost-empty thresholds;
- true simultaneous read and write in one cycle;
- a fill-level output, a registered read-data valid strobe, and sticky overflow/underflow error flags.

It sits between a producer and a consumer running on the same clock.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each stored word.
- DEPTH, 256, number of entries; power of two, at least 4.
- AF_LEVEL, DEPTH-2, almost_full asserts when count >= AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL; range 0..DEPTH-1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- data_in  in  DATA_WIDTH  write data.
- write_enable  in  1  write request.
- read_enable  in  1  read request.
- err_clear  in  1  synchronous clear of overflow and underflow.
- data_out  out  DATA_WIDTH  registered read data.
- data_valid  out  1  one-cycle strobe; data_out holds a newly read word.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky; set by a write while full.
- underflow  out  1  sticky; set by a read while empty.

## Operation
Storage and pointers:
- Storage is a DEPTH x DATA_WIDTH array. Memory contents are not reset.
- Write and read pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0 with no compare logic.
- count is a registered counter and is the single source for all four status flags. The flags are combinational decodes of count.

Acceptance:
- A write is accepted when write_enable && !full, evaluated on the pre-edge full. On acceptance, mem[wptr] <= data_in and wptr increments.
- A read is accepted when read_enable && !empty, evaluated on the pre-edge empty. On acceptance, data_out <= mem[rptr], rptr increments, and data_valid <= 1.

Count update:
- Write only: count + 1.
- Read only: count - 1.
- Both accepted: count is unchanged and both pointers advance.
- Neither: count is held.

Boundary cases:
- Full with both requests: the read is accepted, the write is rejected, and overflow is set. count becomes DEPTH-1.
- Empty with both requests: the write is accepted, the read is rejected, and underflow is set. count becomes 1, and data_out/data_valid are unchanged (data_valid = 0). There is no fall-through.
- Rejected write: no state change except overflow <= 1.
- Rejected read: no state change except underflow <= 1. data_valid = 0 and data_out holds.

Outputs and error flags:
- data_out holds its last value when no read is accepted.
- data_valid is high only in the cycle following an accepted-read edge.
- err_clear clears overflow/underflow on the next edge. If an error event occurs in the same cycle, set wins.

## Timing
- Reset (asynchronous, rst low) sets these values immediately, with no clock required:
  - pointers = 0, count = 0;
  - data_out = 0, data_valid = 0;
  - overflow = 0, underflow = 0;
  - empty = 1, full = 0, almost_full = 0, almost_empty = 1.
- Reset mid-operation discards all buffered words. Operation resumes on the first rising edge after rst deasserts.
- Write-to-read latency:
  - A write accepted at edge N makes empty fall after edge N.
  - A read presented in the following cycle is accepted at edge N+1.
  - data_out/data_valid are valid after edge N+1.
- Read latency is 1 cycle from the accepting edge to data_out.
- Flags update in the same cycle as count, i.e. directly after the accepting edge.
- Sustained throughput: one write and one read per cycle at any occupancy from 1 to DEPTH-1.

## Test plan
- Reset check: hold rst low, then release → count=0, empty=1, almost_empty=1, full=0, data_out=0, data_valid=0. Assert rst mid-stream with 5 words stored → count=0 and empty=1 immediately, without a clock edge.
- Fill/drain (DEPTH=8, AF_LEVEL=6, AE_LEVEL=1): write 0x01..0x08 → almost_full rises at count 6, full at 8. Read 8 times → data_out 0x01..0x08 in order, each with a data_valid pulse; almost_empty rises at count 1, empty at 0.
- Wrap-around (DEPTH=8): 20 cycles of interleaved write/read, 3 words resident → pointers wrap at least twice and the data sequence stays intact.
- Simultaneous read and write at count 4 → count stays 4, data_out = oldest word. Both at full → count becomes 7, overflow = 1. Both at empty → count becomes 1, underflow = 1, data_valid = 0.
- Errors: write at full sets overflow; read at empty sets underflow; FIFO contents are unchanged. err_clear for one cycle clears both flags. err_clear in the same cycle as a new overflow event → overflow stays 1.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock parametrised FIFO with occupancy counter, registered read data,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     write_enable,
  input  logic                     read_enable,
  input  logic                     err_clear,
  output logic [DATA_WIDTH-1:0]    data_out,
  output logic                     data_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic                  wr_accept;
  logic                  rd_accept;

  // All status flags decode the one registered counter, so they can never disagree.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  assign wr_accept = write_enable && !full;
  assign rd_accept = read_enable  && !empty;

  // NOTE: the storage array has no reset so it maps onto plain RAM; stale words are
  // unreachable because the pointers and count are reset.
  always_ff @(posedge clk) begin
    if (wr_accept) mem[wptr] <= data_in;
  end

  // NOTE: non-blocking assignments keep every register sampling pre-edge values,
  // which is what makes the simultaneous read/write cases order-independent.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (wr_accept) wptr <= wptr + PTR_W'(1);
      if (rd_accept) begin
        rptr     <= rptr + PTR_W'(1);
        data_out <= mem[rptr];
      end
      data_valid <= rd_accept;

      case ({wr_accept, rd_accept})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      // A new error event outranks a clear arriving in the same cycle.
      if (write_enable && full)      overflow <= 1'b1;
      else if (err_clear)            overflow <= 1'b0;

      if (read_enable && empty)      underflow <= 1'b1;
      else if (err_clear)            underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo (DEPTH=8): queue-based reference model compared every cycle,
// directed boundary scenarios with literal expectations, and randomized traffic.
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic          clk;
  logic          rst;
  logic [DW-1:0] data_in;
  logic          write_enable;
  logic          read_enable;
  logic          err_clear;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [3:0]    count;
  logic          overflow;
  logic          underflow;

  sync_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH),
    .AF_LEVEL  (AF),
    .AE_LEVEL  (AE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .data_in     (data_in),
    .write_enable(write_enable),
    .read_enable (read_enable),
    .err_clear   (err_clear),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: the FIFO contents as a queue, plus the registered outputs.
  logic [DW-1:0] model_q[$];
  logic [DW-1:0] m_dout  = '0;
  logic          m_valid = 1'b0;
  logic          m_ovf   = 1'b0;
  logic          m_udf   = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      model_q.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      bit was_full, was_empty, wa, ra;
      was_full  = (model_q.size() == DEPTH);
      was_empty = (model_q.size() == 0);
      wa = write_enable && !was_full;
      ra = read_enable && !was_empty;
      if (write_enable && was_full) m_ovf = 1'b1;
      else if (err_clear)           m_ovf = 1'b0;
      if (read_enable && was_empty) m_udf = 1'b1;
      else if (err_clear)           m_udf = 1'b0;
      m_valid = ra;
      if (ra) m_dout = model_q.pop_front();
      if (wa) model_q.push_back(data_in);
    end
  end

  // Compare process: outputs are stable away from the rising edge.
  always @(negedge clk) begin
    int n;
    n = model_q.size();
    check("count",        32'(count),        32'(n));
    check("full",         32'(full),         32'(n == DEPTH));
    check("empty",        32'(empty),        32'(n == 0));
    check("almost_full",  32'(almost_full),  32'(n >= AF));
    check("almost_empty", 32'(almost_empty), 32'(n <= AE));
    check("data_valid",   32'(data_valid),   32'(m_valid));
    check("data_out",     32'(data_out),     32'(m_dout));
    check("overflow",     32'(overflow),     32'(m_ovf));
    check("underflow",    32'(underflow),    32'(m_udf));
  end

  // One clock cycle of stimulus; called and returns at a falling edge.
  task automatic step(input logic we, input logic re, input logic [DW-1:0] din, input logic clr);
    write_enable = we;
    read_enable  = re;
    data_in      = din;
    err_clear    = clr;
    @(posedge clk);
    @(negedge clk);
    write_enable = 1'b0;
    read_enable  = 1'b0;
    err_clear    = 1'b0;
  endtask

  initial begin
    rst          = 1'b0;
    data_in      = '0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    err_clear    = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_count",  32'(count),        32'd0);
    check("rst_empty",  32'(empty),        32'd1);
    check("rst_ae",     32'(almost_empty), 32'd1);
    check("rst_full",   32'(full),         32'd0);
    check("rst_dout",   32'(data_out),     32'd0);
    check("rst_dvalid", 32'(data_valid),   32'd0);
    rst = 1'b1;
    @(negedge clk);

    // Fill 0x01..0x08
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 1'b0, DW'(i), 1'b0);
      if (i == 5) check("af_at5", 32'(almost_full), 32'd0);
      if (i == 6) check("af_at6", 32'(almost_full), 32'd1);
      if (i == 7) check("full_at7", 32'(full), 32'd0);
    end
    check("full_at8", 32'(full), 32'd1);

    // Write while full: overflow, contents untouched
    step(1'b1, 1'b0, 8'hEE, 1'b0);
    check("ovf_set",     32'(overflow), 32'd1);
    check("ovf_count",   32'(count),    32'd8);

    // Drain: in-order data with a valid pulse each
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b0, 1'b1, '0, 1'b0);
      check("drain_data",  32'(data_out),   32'(i));
      check("drain_valid", 32'(data_valid), 32'd1);
      if (i == 6) check("ae_at2", 32'(almost_empty), 32'd0);
      if (i == 7) check("ae_at1", 32'(almost_empty), 32'd1);
    end
    check("empty_at0", 32'(empty), 32'd1);

    // Read while empty: underflow, no valid, data_out holds
    step(1'b0, 1'b1, '0, 1'b0);
    check("udf_set",    32'(underflow),  32'd1);
    check("udf_valid",  32'(data_valid), 32'd0);
    check("udf_dout",   32'(data_out),   32'h08);

    // One-cycle clear drops both flags
    step(1'b0, 1'b0, '0, 1'b1);
    check("clr_ovf", 32'(overflow),  32'd0);
    check("clr_udf", 32'(underflow), 32'd0);

    // Both requests at empty: write wins, underflow set, no fall-through
    step(1'b1, 1'b1, 8'h5A, 1'b0);
    check("be_count", 32'(count),      32'd1);
    check("be_udf",   32'(underflow),  32'd1);
    check("be_valid", 32'(data_valid), 32'd0);

    // Fill to full then both requests: read wins, overflow set
    step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 1'b0, DW'(8'h60 + i), 1'b0);
    check("bf_full_pre", 32'(full), 32'd1);
    step(1'b1, 1'b1, 8'hFF, 1'b0);
    check("bf_count", 32'(count),    32'd7);
    check("bf_ovf",   32'(overflow), 32'd1);
    check("bf_dout",  32'(data_out), 32'h5A);

    // Clear racing a new overflow event: set wins
    step(1'b1, 1'b0, 8'h77, 1'b0);
    step(1'b1, 1'b0, 8'h78, 1'b1);
    check("clr_vs_set", 32'(overflow), 32'd1);

    // Simultaneous read/write at count 4
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0, 1'b1);
    check("c4_pre", 32'(count), 32'd4);
    step(1'b1, 1'b1, 8'hA4, 1'b0);
    check("c4_count", 32'(count),    32'd4);
    check("c4_dout",  32'(data_out), 32'h64);

    // Wrap-around: interleaved traffic around 3 resident words
    while (count > 3) step(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, DW'($urandom), 1'b0);
    check("wrap_count", 32'(count), 32'd3);

    // Randomized traffic including clears
    for (int i = 0; i < 400; i++)
      step(1'(($urandom % 100) < 55), 1'(($urandom % 100) < 50), DW'($urandom), 1'(($urandom % 16) == 0));

    // Mid-stream asynchronous reset with 5 words stored
    while (count != 0) step(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DW'(8'h30 + i), 1'b0);
    check("mid_pre", 32'(count), 32'd5);
    #2 rst = 1'b0;
    #1;
    check("mid_count", 32'(count), 32'd0);
    check("mid_empty", 32'(empty),  32'd1);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b0, 8'hC3, 1'b0);
    step(1'b0, 1'b1, '0, 1'b0);
    check("post_rst_dout", 32'(data_out), 32'hC3);
    check("post_rst_cnt",  32'(count),    32'd0);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
